// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: sync/filter ps2 lines, deserialize frames, track F0/E0 prefixes.
module ps2_keyboard #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       frame_err,
    output logic [7:0] letra
);

    localparam int unsigned FW = 5;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned BW = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    logic          clk_s1, clk_s2, data_s1, data_s2;
    logic          filt, filt_d;
    logic [FW-1:0] fcnt;
    logic          fall_c;

    state_t        state, state_n;
    logic [7:0]    sr, sr_n;
    logic [BW-1:0] bcnt, bcnt_n;
    logic          par_ok, par_ok_n;
    logic [TW-1:0] to_cnt, to_cnt_n;
    logic [7:0]    code_n, letra_n;
    logic          cv_n, fe_n;
    logic          brk, brk_n, ext, ext_n;

    // Two-stage synchronizers; idle bus level is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            clk_s1  <= ps2_clk;
            clk_s2  <= clk_s1;
            data_s1 <= ps2_data;
            data_s2 <= data_s1;
        end
    end

    // Clock filter: accept a new level after FILTER_LEN consecutive differing samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt   <= 1'b1;
            filt_d <= 1'b1;
            fcnt   <= '0;
        end else begin
            filt_d <= filt;
            if (clk_s2 == filt) begin
                fcnt <= '0;
            end else if (fcnt == FW'(FILTER_LEN - 1)) begin
                filt <= clk_s2;
                fcnt <= '0;
            end else begin
                fcnt <= fcnt + FW'(1);
            end
        end
    end

    assign fall_c = filt_d & ~filt;

    // Receiver state and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sr         <= '0;
            bcnt       <= '0;
            par_ok     <= 1'b0;
            to_cnt     <= '0;
            code       <= 8'h00;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            letra      <= 8'h00;
            brk        <= 1'b0;
            ext        <= 1'b0;
        end else begin
            state      <= state_n;
            sr         <= sr_n;
            bcnt       <= bcnt_n;
            par_ok     <= par_ok_n;
            to_cnt     <= to_cnt_n;
            code       <= code_n;
            code_valid <= cv_n;
            frame_err  <= fe_n;
            letra      <= letra_n;
            brk        <= brk_n;
            ext        <= ext_n;
        end
    end

    // Next-state: frame deserializer, timeout and prefix tracking
    always_comb begin
        state_n  = state;
        sr_n     = sr;
        bcnt_n   = bcnt;
        par_ok_n = par_ok;
        to_cnt_n = '0;
        code_n   = code;
        cv_n     = 1'b0;
        fe_n     = 1'b0;
        letra_n  = letra;
        brk_n    = brk;
        ext_n    = ext;

        if (state != IDLE && !fall_c) begin
            if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                state_n = IDLE;
            end else begin
                to_cnt_n = to_cnt + TW'(1);
            end
        end

        if (fall_c) begin
            case (state)
                IDLE: begin
                    if (!data_s2) begin
                        state_n = DATA;
                        bcnt_n  = '0;
                    end
                end
                DATA: begin
                    sr_n   = {data_s2, sr[7:1]};
                    bcnt_n = bcnt + BW'(1);
                    if (bcnt == BW'(7)) begin
                        state_n = PARITY;
                    end
                end
                PARITY: begin
                    par_ok_n = ^sr ^ data_s2;
                    state_n  = STOP;
                end
                STOP: begin
                    state_n = IDLE;
                    if (data_s2 && par_ok) begin
                        code_n = sr;
                        cv_n   = 1'b1;
                        if (sr == 8'hF0) begin
                            brk_n = 1'b1;
                        end else if (sr == 8'hE0) begin
                            ext_n = 1'b1;
                        end else begin
                            if (!brk && !ext) begin
                                letra_n = sr;
                            end
                            brk_n = 1'b0;
                            ext_n = 1'b0;
                        end
                    end else begin
                        fe_n = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_keyboard.sv
// Self-checking bench for ps2_keyboard: frame-level model, per-cycle compare.
module tb_ps2_keyboard;

    localparam int unsigned FILT = 8;
    localparam int unsigned TOUT = 2000;
    localparam int HALF = 40;
    localparam int GAP  = 60;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] code;
    logic       code_valid;
    logic       frame_err;
    logic [7:0] letra;

    ps2_keyboard #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .code       (code),
        .code_valid (code_valid),
        .frame_err  (frame_err),
        .letra      (letra)
    );

    always #10 clk = ~clk;

    typedef struct {
        bit         err;
        logic [7:0] code;
        logic [7:0] letra;
    } exp_t;

    exp_t exp_q [256];
    int   wr = 0;
    int   rd = 0;

    // Model state (stimulus side)
    logic [7:0] m_code  = 8'h00;
    logic [7:0] m_letra = 8'h00;
    bit         m_brk   = 0;
    bit         m_ext   = 0;

    // Literal pin requests
    int         pin_seq = 0;
    int         pin_done = 0;
    logic [7:0] pin_code, pin_letra;
    string      pin_name;

    int n_total = 0;
    int n_pass  = 0;
    logic [7:0] cur_code  = 8'h00;
    logic [7:0] cur_letra = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Compare DUT against the model every cycle, away from the active edge
    always @(negedge clk) begin
        if (!rst_n) begin
            cur_code  = 8'h00;
            cur_letra = 8'h00;
            chk("rst_code", 32'(code), 32'h00);
            chk("rst_letra", 32'(letra), 32'h00);
            chk("rst_strobes", 32'({code_valid, frame_err}), 32'h0);
        end else begin
            if (code_valid || frame_err) begin
                chk("strobe_expected", 32'(wr != rd), 32'h1);
                if (wr != rd) begin
                    chk("strobe_kind", 32'({code_valid, frame_err}),
                        exp_q[rd % 256].err ? 32'h1 : 32'h2);
                    chk("strobe_code", 32'(code), 32'(exp_q[rd % 256].code));
                    chk("strobe_letra", 32'(letra), 32'(exp_q[rd % 256].letra));
                    cur_code  = exp_q[rd % 256].code;
                    cur_letra = exp_q[rd % 256].letra;
                    rd++;
                end
            end else begin
                chk("hold_code", 32'(code), 32'(cur_code));
                chk("hold_letra", 32'(letra), 32'(cur_letra));
            end
            if (pin_seq != pin_done) begin
                chk({pin_name, "_code"}, 32'(code), 32'(pin_code));
                chk({pin_name, "_letra"}, 32'(letra), 32'(pin_letra));
                chk({pin_name, "_all_strobes_seen"}, 32'(rd), 32'(wr));
                pin_done = pin_seq;
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Frame-level rule model: one expected strobe per complete frame
    task automatic model_frame(input logic [7:0] b, input bit bad);
        if (!bad) begin
            m_code = b;
            if (b == 8'hF0) m_brk = 1;
            else if (b == 8'hE0) m_ext = 1;
            else begin
                if (!m_brk && !m_ext) m_letra = b;
                m_brk = 0;
                m_ext = 0;
            end
        end
        exp_q[wr % 256] = '{err: bad, code: m_code, letra: m_letra};
        wr++;
    endtask

    task automatic send_bit(input logic v, input bit glitch);
        ps2_data = v;
        if (glitch) begin
            wait_cycles(HALF / 2);
            ps2_clk = 1'b0;
            wait_cycles(3);
            ps2_clk = 1'b1;
            wait_cycles(HALF / 2 - 3);
        end else begin
            wait_cycles(HALF);
        end
        ps2_clk = 1'b0;
        wait_cycles(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input bit glitch);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        model_frame(b, bad_par || bad_stop);
        for (int i = 0; i < 11; i++) send_bit(bits[i], glitch && i == 4);
        ps2_data = 1'b1;
        wait_cycles(GAP);
    endtask

    task automatic send_partial(input int nbits);
        send_bit(1'b0, 0);
        for (int i = 0; i < nbits; i++) send_bit(1'($urandom_range(0, 1)), 0);
        ps2_data = 1'b1;
    endtask

    task automatic pin(input string name, input logic [7:0] c, input logic [7:0] l);
        pin_name  = name;
        pin_code  = c;
        pin_letra = l;
        pin_seq++;
        wait_cycles(3);
    endtask

    task automatic model_reset();
        m_code = 8'h00;
        m_letra = 8'h00;
        m_brk = 0;
        m_ext = 0;
    endtask

    initial begin
        wait_cycles(5);
        rst_n = 1'b1;
        wait_cycles(20);

        // Plain make code
        send_frame(8'h1D, 0, 0, 0);
        pin("make_1d", 8'h1D, 8'h1D);

        // Break sequence then new make
        send_frame(8'hF0, 0, 0, 0);
        send_frame(8'h1D, 0, 0, 0);
        pin("break_1d", 8'h1D, 8'h1D);
        send_frame(8'h23, 0, 0, 0);
        pin("make_23", 8'h23, 8'h23);

        // Extended make and extended break leave letra alone
        send_frame(8'hE0, 0, 0, 0);
        send_frame(8'h75, 0, 0, 0);
        send_frame(8'hE0, 0, 0, 0);
        send_frame(8'hF0, 0, 0, 0);
        send_frame(8'h75, 0, 0, 0);
        pin("ext_75", 8'h75, 8'h23);
        send_frame(8'h1B, 0, 0, 0);
        pin("make_1b", 8'h1B, 8'h1B);

        // Parity error, then recovery
        send_frame(8'h1B, 1, 0, 0);
        pin("bad_parity", 8'h1B, 8'h1B);
        send_frame(8'h1C, 0, 0, 0);
        pin("make_1c", 8'h1C, 8'h1C);

        // Stop-bit error
        send_frame(8'h2A, 0, 1, 0);
        pin("bad_stop", 8'h1C, 8'h1C);

        // Glitch in IDLE and mid-frame
        ps2_clk = 1'b0;
        wait_cycles(3);
        ps2_clk = 1'b1;
        wait_cycles(GAP);
        send_frame(8'h4D, 0, 0, 1);
        pin("glitch_4d", 8'h4D, 8'h4D);

        // Truncated frame followed by timeout
        send_partial(4);
        wait_cycles(TOUT + 500);
        send_frame(8'h23, 0, 0, 0);
        pin("timeout_23", 8'h23, 8'h23);

        // Reset mid-frame
        send_partial(4);
        rst_n = 1'b0;
        model_reset();
        wait_cycles(5);
        rst_n = 1'b1;
        wait_cycles(20);
        send_frame(8'h23, 0, 0, 0);
        pin("reset_23", 8'h23, 8'h23);

        // Randomized frames against the model
        for (int k = 0; k < 30; k++) begin
            logic [7:0] b;
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel == 0) b = 8'hF0;
            else if (sel == 1) b = 8'hE0;
            else b = 8'($urandom_range(0, 255));
            send_frame(b, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
                       $urandom_range(0, 3) == 0);
        end
        pin("random_end", m_code, m_letra);

        wait_cycles(10);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ps2_keyboard.md
# ps2_keyboard

PS/2 keyboard receiver that produces the `letra` scan-code byte consumed by the sprite and game logic. It filters and synchronizes the keyboard's open-collector clock and data lines and deserializes 11-bit device-to-host frames. It checks start, odd-parity and stop bits, then tracks the `F0` (break) and `E0` (extended) prefixes so that `letra` holds the last plain make code pressed. Raw bytes are also exported as a one-cycle strobe stream.

## Interface
- `FILTER_LEN`, default 8: consecutive identical synchronized `ps2_clk` samples needed to change the filtered clock (2..16).
- `TIMEOUT_CYCLES`, default 50000: `clk` cycles without a filtered falling edge, mid-frame, before the FSM aborts to IDLE (1 ms at 50 MHz).
- `clk` input 1: system clock, all logic on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `ps2_clk` input 1: raw keyboard clock, asynchronous to `clk`.
- `ps2_data` input 1: raw keyboard data, asynchronous to `clk`.
- `code` output 8: last correctly received byte, raw.
- `code_valid` output 1: one-cycle strobe; `code` updated this cycle.
- `frame_err` output 1: one-cycle strobe on parity or stop-bit failure.
- `letra` output 8: last non-extended make code; held otherwise.

## Operation
- Reset values: `code`=8'h00, `code_valid`=0, `frame_err`=0, `letra`=8'h00. The FSM resets to IDLE, the shift register and bit counter to 0, and the `brk`/`ext` flags to 0. The filtered clock and both synchronizer stages reset to 1 (idle bus).
- `ps2_clk` and `ps2_data` each pass through a 2-FF synchronizer.
- The filtered clock takes the synchronized clock value only after `FILTER_LEN` equal consecutive samples.
- A falling edge (`fall`) is a filtered 1->0 transition. It is high for one cycle.
- `ps2_data` is sampled from its synchronizer output in the `fall` cycle.
- The FSM acts only on `fall`, except for the timeout:
  - IDLE: if data=0, go to DATA with count=0. If data=1, stay in IDLE and report no error.
  - DATA: shift `sr <= {data, sr[7:1]}` (LSB first) and increment count. After the 8th bit, go to PARITY.
  - PARITY: store `par_ok = ^sr ^ data` (1 means odd parity is correct). Go to STOP.
  - STOP: if data=1 and `par_ok`, accept the byte; otherwise pulse `frame_err`. Go to IDLE.
- Timeout: in DATA, PARITY or STOP, a counter counts cycles since the last `fall` and resets on each `fall`. When it reaches `TIMEOUT_CYCLES`, the FSM goes to IDLE and discards the partial byte. No `frame_err` is raised. The counter is held at 0 in IDLE.
- On an accepted byte `b`:
  - `code <= b` and `code_valid` is pulsed.
  - If `b`=F0, set `brk`. If `b`=E0, set `ext`.
  - Otherwise, if `brk`=0 and `ext`=0, set `letra <= b`. Clear both `brk` and `ext`.
- `brk` and `ext` persist across frame errors and timeouts. The next accepted non-prefix byte clears them.
- Release codes and extended codes never change `letra`.

## Timing
- Pin-to-`fall` latency is 2 sync cycles plus `FILTER_LEN` filter cycles plus 1 edge-detect cycle.
- `code`, `code_valid`, `letra` and `frame_err` are registered. They update on the rising edge after the `fall` cycle that samples the stop bit.
- `code_valid` and `frame_err` are high for exactly one cycle and are never asserted together.
- `letra` changes in the same cycle that `code_valid` rises.
- Minimum byte spacing is one full frame, so no back-pressure or buffering is required.
- `rst_n` low mid-frame clears everything immediately. The first frame after release decodes normally.

## Test plan
- Frame 0x1D, parity 1, stop 1, PS/2 clock 12.5 kHz, `clk` 50 MHz -> `code`=1D, one `code_valid` pulse, `letra`=1D, no `frame_err`.
- With `letra`=1D, send F0, 1D, then 23 (parity 0) -> three `code_valid` pulses. `letra` stays 1D after F0 1D, then becomes 23.
- With `letra`=23, send E0 75 then E0 F0 75 -> five `code_valid` pulses, `letra` stays 23. Then send 1B -> `letra`=1B.
- Frame 0x1B with parity 0 (wrong) -> single `frame_err` pulse, no `code_valid`, `code` and `letra` unchanged. The next frame 0x1C (parity 0) decodes correctly.
- 3-cycle low glitch on `ps2_clk` in IDLE and mid-DATA -> no bit shifted. A frame containing the glitch still decodes its correct value.
- Send start plus 4 data bits, then idle for more than 50000 cycles -> no strobes, FSM in IDLE. The next full 0x23 frame gives `letra`=23. Repeat with `rst_n` pulsed mid-frame -> same result.
